// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: opcodes, FSM states and
// lane-select constants used by the load extractor and store merger.
package dm_access_unit_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2
  } state_t;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       HALF_LO = 1'b0;
  localparam logic       HALF_HI = 1'b1;

endpackage

// File: rtl/dm_access_unit_lane_mux.sv
// Combinational lane logic: sub-word load extraction/extension and the
// byte/halfword merge that feeds the read-modify-write store path.
module dm_lane_mux
  import dm_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    logic signed [8:0] t;
    t = $signed({sgn & v[7], v});
    return 32'(t);
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    logic signed [16:0] t;
    t = $signed({sgn & v[15], v});
    return 32'(t);
  endfunction

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   load_val = ext8(byte_v, 1'b1);
      OP_LBU:  load_val = ext8(byte_v, 1'b0);
      OP_LH:   load_val = ext16(half_v, 1'b1);
      OP_LHU:  load_val = ext16(half_v, 1'b0);
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = word;
    if (op == OP_SB) begin
      case (lane)
        LANE_B0: merged = {word[31:8], wdata[7:0]};
        LANE_B1: merged = {word[31:16], wdata[7:0], word[7:0]};
        LANE_B2: merged = {word[31:24], wdata[7:0], word[15:0]};
        LANE_B3: merged = {wdata[7:0], word[23:0]};
        default: merged = word;
      endcase
    end else if (op == OP_SH) begin
      if (lane[1] == HALF_HI) merged = {wdata, word[15:0]};
      else if (lane[1] == HALF_LO) merged = {word[31:16], wdata};
    end
  end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store initiator for a word-only memory port. Sub-word stores are
// done as read (ACCESS) then merged write (MERGE); bad accesses never touch memory.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_LSB  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        req_err;
  logic        is_sub_store;
  logic        is_load;

  always_comb begin
    req_err = (addr >= ADDR_LIMIT)
            || (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0])
            || (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00));
    is_sub_store = (op_q == OP_SB) || (op_q == OP_SH);
    is_load      = (op_q <= OP_LW);
  end

  dm_lane_mux u_lane_mux (
    .word     (state == ST_MERGE ? old_q : mem_rdata),
    .wdata    (wdata_q[15:0]),
    .op       (op_q),
    .lane     (addr_q[1:0]),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req && !req_err) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = is_sub_store ? ST_MERGE : ST_IDLE;
      ST_MERGE:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates the write strobe so an aborted MERGE never commits.
  always_comb begin
    ready     = (state == ST_IDLE);
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state != ST_IDLE) mem_addr = {addr_q[31:ADDR_LSB], {ADDR_LSB{1'b0}}};
    if (state == ST_ACCESS && op_q == OP_SW) begin
      mem_we    = !reset;
      mem_wdata = wdata_q;
    end else if (state == ST_MERGE) begin
      mem_we    = !reset;
      mem_wdata = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req) begin
      op_q    <= op;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
    if (state == ST_ACCESS) old_q <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: if (req && req_err) begin
          done <= 1'b1;
          err  <= 1'b1;
        end
        ST_ACCESS: begin
          if (!is_sub_store) done <= 1'b1;
          if (is_load) rdata <= load_val;
        end
        ST_MERGE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
